// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
// Default timing constants assume a 50 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_LONG_CYCLES     = 50_000_000;  // 1 s
    localparam int DEF_REPEAT_CYCLES   = 12_500_000;  // 250 ms

    // Bits needed to hold values 0..max_count (never less than one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One key lane: 2-FF synchroniser, debounce filter and press/long/release FSM.
// Optional BTN_AUTOREPEAT_EN adds periodic press pulses while held in LONG.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic p_raw,          // already polarity-normalised, 1 = pressed
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic held_long
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    logic          sync1, sync2;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    btn_state_t    state;
    logic          accept_press, accept_release;

    // NOTE: non-blocking assignments make sync2 take the previous sync1, giving two real stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= p_raw;
            sync2 <= sync1;
        end
    end

    // A change is accepted on the edge where it has been seen for DEBOUNCE_CYCLES cycles.
    assign accept_press   = (sync2 != level) && (dcnt == DEB_LAST) &&  sync2;
    assign accept_release = (sync2 != level) && (dcnt == DEB_LAST) && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            dcnt  <= '0;
        end else if (sync2 == level) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            level <= sync2;
            dcnt  <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hcnt          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt          <= '0;
`endif
        end else begin
            // NOTE: pulses default low every cycle so each one lasts exactly one clk.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_press) begin
                        state       <= PRESSED;
                        hcnt        <= '0;
                        press_pulse <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release takes priority over reaching the long-press threshold.
                    if (accept_release) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (hcnt == LONG_LAST) begin
                        state      <= LONG;
                        long_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt       <= '0;
`endif
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LONG: begin
                    // hcnt is left at its threshold here, so a very long hold cannot re-fire.
                    if (accept_release) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt          <= '0;
                    end else if (rcnt == REP_LAST) begin
                        rcnt        <= '0;
                        press_pulse <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign held_long = (state == LONG);

endmodule

// File: rtl/btn_array_debounce.sv
// N-key push-button conditioner: polarity normalisation and bus packing around btn_channel lanes.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses during a long hold.
module btn_array_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held_long
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_array_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_array_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_array_debounce: REPEAT_CYCLES must be >= 1");
    end

    // Inverting before the synchroniser is harmless and lets every lane reset to 0 = released.
    logic [N_BTN-1:0] p_raw;
    assign p_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .p_raw         (p_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i]),
            .held_long     (btn_held_long[i])
        );
    end

endmodule

// File: tb/tb_btn_array_debounce.sv
// Scoreboard bench for btn_array_debounce: expected pulses are queued at stimulus time and matched per cycle.
module tb_btn_array_debounce;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;
    localparam int LAT = DEB + 2;
    localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_held_long;

    btn_array_debounce #(
        .N_BTN           (N),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_long      (btn_long),
        .btn_held_long (btn_held_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Every pulse seen must be the next expected event, at the expected cycle.
    always @(negedge clk) begin : monitor
        ev_t  e;
        logic b;
        for (int ch = 0; ch < N; ch++) begin
            for (int k = 0; k < 3; k++) begin
                b = (k == K_PRESS) ? btn_press[ch] : (k == K_RELEASE) ? btn_release[ch] : btn_long[ch];
                if (b === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse: got cyc=%0d ch=%0d kind=%0d, want no pulse", cyc, ch, k);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc !== cyc || e.ch !== ch || e.kind !== k) begin
                            bad++;
                            $display("FAIL pulse_match: got cyc=%0d ch=%0d kind=%0d, want cyc=%0d ch=%0d kind=%0d",
                                     cyc, ch, k, e.cyc, e.ch, e.kind);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push(input int c, input int ch, input int k);
        exp_q.push_back('{c, ch, k});
    endtask

    task automatic drain(input string name);
        int budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pulses outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = '1;
        tick(3);
        total++; if (btn_level !== 4'b0)     begin bad++; $display("FAIL reset_level: got %b want 0000", btn_level); end
        total++; if (btn_press !== 4'b0)     begin bad++; $display("FAIL reset_press: got %b want 0000", btn_press); end
        total++; if (btn_release !== 4'b0)   begin bad++; $display("FAIL reset_release: got %b want 0000", btn_release); end
        total++; if (btn_long !== 4'b0)      begin bad++; $display("FAIL reset_long: got %b want 0000", btn_long); end
        total++; if (btn_held_long !== 4'b0) begin bad++; $display("FAIL reset_held: got %b want 0000", btn_held_long); end
        rst = 1'b0;
        tick(10);
        total++; if (btn_level !== 4'b0) begin bad++; $display("FAIL idle_level: got %b want 0000", btn_level); end
        drain("reset");
    endtask

    task automatic test_press();
        int t0, t1;
        t0 = cyc;
        btn_in[0] = 1'b0;
        push(t0 + LAT, 0, K_PRESS);
        wait_cyc(t0 + LAT - 1);
        total++; if (btn_level !== 4'b0000) begin bad++; $display("FAIL press_early: got %b want 0000", btn_level); end
        tick(1);
        total++; if (btn_level !== 4'b0001) begin bad++; $display("FAIL press_level: got %b want 0001", btn_level); end
        wait_cyc(t0 + 10);
        btn_in[0] = 1'b1;
        t1 = cyc;
        push(t1 + LAT, 0, K_RELEASE);
        wait_cyc(t1 + LAT);
        total++; if (btn_level !== 4'b0000) begin bad++; $display("FAIL press_release_level: got %b want 0000", btn_level); end
        drain("press");
    endtask

    task automatic test_bounce();
        localparam logic [0:8] BOUNCE = 9'b000100011;
        for (int i = 0; i < 9; i++) begin
            btn_in[1] = BOUNCE[i];
            tick(1);
            total++;
            if (btn_level[1] !== 1'b0) begin
                bad++;
                $display("FAIL bounce_level: step %0d got %b want 0", i, btn_level[1]);
            end
        end
        tick(8);
        total++; if (btn_level !== 4'b0000) begin bad++; $display("FAIL bounce_final: got %b want 0000", btn_level); end
        drain("bounce");
    endtask

    task automatic test_long();
        int t0;
        t0 = cyc;
        btn_in[2] = 1'b0;
        push(t0 + LAT, 2, K_PRESS);
        push(t0 + LAT + LNG, 2, K_LONG);
`ifdef BTN_AUTOREPEAT_EN
        for (int r = t0 + LAT + LNG + REP; r < t0 + 40 + LAT; r += REP) push(r, 2, K_PRESS);
`endif
        push(t0 + 40 + LAT, 2, K_RELEASE);
        wait_cyc(t0 + LAT + LNG - 1);
        total++; if (btn_held_long !== 4'b0000) begin bad++; $display("FAIL long_early: got %b want 0000", btn_held_long); end
        tick(1);
        total++; if (btn_held_long !== 4'b0100) begin bad++; $display("FAIL long_held: got %b want 0100", btn_held_long); end
        wait_cyc(t0 + 40);
        btn_in[2] = 1'b1;
        wait_cyc(t0 + 40 + LAT - 1);
        total++;
        if ({btn_level[2], btn_held_long[2]} !== 2'b11) begin
            bad++; $display("FAIL long_before_release: got %b want 11", {btn_level[2], btn_held_long[2]});
        end
        tick(1);
        total++;
        if ({btn_level[2], btn_held_long[2]} !== 2'b00) begin
            bad++; $display("FAIL long_after_release: got %b want 00", {btn_level[2], btn_held_long[2]});
        end
        drain("long");
    endtask

    // ch1 releases on the very edge its hold would go long; ch3 releases one cycle later.
    task automatic test_boundary();
        int t0;
        t0 = cyc;
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b0;
        push(t0 + LAT, 1, K_PRESS);
        push(t0 + LAT, 3, K_PRESS);
        push(t0 + LAT + LNG, 1, K_RELEASE);
        push(t0 + LAT + LNG, 3, K_LONG);
        push(t0 + LAT + LNG + 1, 3, K_RELEASE);
        wait_cyc(t0 + LNG);
        btn_in[1] = 1'b1;
        tick(1);
        btn_in[3] = 1'b1;
        wait_cyc(t0 + LAT + LNG);
        total++; if (btn_held_long !== 4'b1000) begin bad++; $display("FAIL boundary_held: got %b want 1000", btn_held_long); end
        tick(1);
        total++; if (btn_held_long !== 4'b0000) begin bad++; $display("FAIL boundary_clear: got %b want 0000", btn_held_long); end
        drain("boundary");
    endtask

    task automatic test_simul_reset();
        int t0, tr;
        t0 = cyc;
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        push(t0 + LAT, 0, K_PRESS);
        push(t0 + LAT, 3, K_PRESS);
        wait_cyc(t0 + 12);
        total++; if (btn_level !== 4'b1001) begin bad++; $display("FAIL simul_level: got %b want 1001", btn_level); end
        rst = 1'b1;
        tick(1);
        total++; if (btn_level !== 4'b0000) begin bad++; $display("FAIL midreset_level: got %b want 0000", btn_level); end
        total++; if ((btn_press | btn_release | btn_long | btn_held_long) !== 4'b0000) begin
            bad++; $display("FAIL midreset_pulses: got %b want 0000", btn_press | btn_release | btn_long | btn_held_long);
        end
        tick(2);
        rst = 1'b0;
        tr  = cyc;
        push(tr + LAT, 0, K_PRESS);
        push(tr + LAT, 3, K_PRESS);
        wait_cyc(tr + LAT - 1);
        total++; if (btn_level !== 4'b0000) begin bad++; $display("FAIL repress_early: got %b want 0000", btn_level); end
        tick(1);
        total++; if (btn_level !== 4'b1001) begin bad++; $display("FAIL repress_level: got %b want 1001", btn_level); end
        wait_cyc(tr + 10);
        btn_in = '1;
        push(tr + 10 + LAT, 0, K_RELEASE);
        push(tr + 10 + LAT, 3, K_RELEASE);
        drain("simul_reset");
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_boundary();
        test_simul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
